// File: rtl/alu_seq_pkg.sv
// Shared state encoding and unit-select codes for the ALU operation sequencer.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SEL_ARITH = 2'b00,
    SEL_LOGIC = 2'b01,
    SEL_CMP   = 2'b10,
    SEL_SHIFT = 2'b11
  } sel_t;

endpackage

// File: rtl/seq_timeout_cnt.sv
// 4-bit clear/increment counter bounding how long the sequencer waits in EXEC.
module seq_timeout_cnt #(
  parameter int unsigned TIMEOUT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == 4'(TIMEOUT - 1));

endmodule

// File: rtl/alu_op_sequencer.sv
// Accepts one command, enables the selected ALU unit, and returns its result or a timeout error.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned TIMEOUT   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [3:0]           cmd_func,
  input  logic [IN_WIDTH-1:0]  cmd_a,
  input  logic [IN_WIDTH-1:0]  cmd_b,
  output logic [IN_WIDTH-1:0]  unit_a,
  output logic [IN_WIDTH-1:0]  unit_b,
  output logic [1:0]           unit_fuc,
  output logic                 arith_en,
  output logic                 logic_en,
  output logic                 cmp_en,
  output logic                 shift_en,
  input  logic                 arith_flag,
  input  logic                 logic_flag,
  input  logic                 cmp_flag,
  input  logic                 shift_flag,
  input  logic [OUT_WIDTH-1:0] arith_out,
  input  logic [OUT_WIDTH-1:0] logic_out,
  input  logic [OUT_WIDTH-1:0] cmp_out,
  input  logic [OUT_WIDTH-1:0] shift_out,
  output logic                 res_valid,
  output logic [OUT_WIDTH-1:0] res_data,
  output logic                 res_err,
  input  logic                 res_ready,
  output logic                 alu_clk_en
);

  state_t                 state_q, state_d;
  sel_t                   sel_q, sel_d;
  logic [IN_WIDTH-1:0]    unit_a_q, unit_a_d;
  logic [IN_WIDTH-1:0]    unit_b_q, unit_b_d;
  logic [1:0]             unit_fuc_q, unit_fuc_d;
  logic [OUT_WIDTH-1:0]   res_data_q, res_data_d;
  logic                   res_err_q, res_err_d;
  logic                   alu_clk_en_q, alu_clk_en_d;
  logic                   accept;
  logic                   expired;
  logic                   sel_flag;
  logic [OUT_WIDTH-1:0]   sel_out;

  assign accept = cmd_valid && (state_q == IDLE);

  seq_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .inc    (state_q == EXEC),
    .expired(expired)
  );

  // Only the selected unit's flag and result are ever looked at.
  always_comb begin
    sel_flag = 1'b0;
    sel_out  = '0;
    case (sel_q)
      SEL_ARITH: begin sel_flag = arith_flag; sel_out = arith_out; end
      SEL_LOGIC: begin sel_flag = logic_flag; sel_out = logic_out; end
      SEL_CMP:   begin sel_flag = cmp_flag;   sel_out = cmp_out;   end
      SEL_SHIFT: begin sel_flag = shift_flag; sel_out = shift_out; end
      default:   begin sel_flag = 1'b0;       sel_out = '0;        end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = EXEC;
      EXEC:    if (sel_flag || expired) state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
    res_valid = (state_q == DONE);
    arith_en  = (state_q == EXEC) && (sel_q == SEL_ARITH);
    logic_en  = (state_q == EXEC) && (sel_q == SEL_LOGIC);
    cmp_en    = (state_q == EXEC) && (sel_q == SEL_CMP);
    shift_en  = (state_q == EXEC) && (sel_q == SEL_SHIFT);
  end

  // A flag on the timeout edge takes priority over the error path.
  always_comb begin
    sel_d      = sel_q;
    unit_a_d   = unit_a_q;
    unit_b_d   = unit_b_q;
    unit_fuc_d = unit_fuc_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    if (accept) begin
      sel_d      = sel_t'(cmd_func[3:2]);
      unit_a_d   = cmd_a;
      unit_b_d   = cmd_b;
      unit_fuc_d = cmd_func[1:0];
    end
    if (state_q == EXEC) begin
      if (sel_flag) begin
        res_data_d = sel_out;
        res_err_d  = 1'b0;
      end else if (expired) begin
        res_data_d = '0;
        res_err_d  = 1'b1;
      end
    end
    // Every EXEC cycle plus the first DONE cycle, i.e. any cycle whose state is or was EXEC.
    alu_clk_en_d = (state_d == EXEC) || (state_q == EXEC);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q        <= SEL_ARITH;
      unit_a_q     <= '0;
      unit_b_q     <= '0;
      unit_fuc_q   <= '0;
      res_data_q   <= '0;
      res_err_q    <= 1'b0;
      alu_clk_en_q <= 1'b0;
    end else begin
      sel_q        <= sel_d;
      unit_a_q     <= unit_a_d;
      unit_b_q     <= unit_b_d;
      unit_fuc_q   <= unit_fuc_d;
      res_data_q   <= res_data_d;
      res_err_q    <= res_err_d;
      alu_clk_en_q <= alu_clk_en_d;
    end
  end

  assign unit_a     = unit_a_q;
  assign unit_b     = unit_b_q;
  assign unit_fuc   = unit_fuc_q;
  assign res_data   = res_data_q;
  assign res_err    = res_err_q;
  assign alu_clk_en = alu_clk_en_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with simple behavioural ALU units on the unit side.
module tb_alu_op_sequencer;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_func;
  logic [7:0]  cmd_a, cmd_b;
  logic [7:0]  unit_a, unit_b;
  logic [1:0]  unit_fuc;
  logic        arith_en, logic_en, cmp_en, shift_en;
  logic [15:0] arith_out, logic_out, cmp_out, shift_out;
  logic        res_valid;
  logic [15:0] res_data;
  logic        res_err;
  logic        res_ready;
  logic        alu_clk_en;

  logic [3:0]  en_v;
  logic [3:0]  flag_v;
  logic [3:0]  force_v;
  int unsigned lat [4];
  int unsigned cnt [4];

  int n_checks;
  int n_fail;

  alu_op_sequencer #(
    .IN_WIDTH (8),
    .OUT_WIDTH(16),
    .TIMEOUT  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_func  (cmd_func),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .unit_a    (unit_a),
    .unit_b    (unit_b),
    .unit_fuc  (unit_fuc),
    .arith_en  (arith_en),
    .logic_en  (logic_en),
    .cmp_en    (cmp_en),
    .shift_en  (shift_en),
    .arith_flag(flag_v[0]),
    .logic_flag(flag_v[1]),
    .cmp_flag  (flag_v[2]),
    .shift_flag(flag_v[3]),
    .arith_out (arith_out),
    .logic_out (logic_out),
    .cmp_out   (cmp_out),
    .shift_out (shift_out),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_err   (res_err),
    .res_ready (res_ready),
    .alu_clk_en(alu_clk_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign en_v = {shift_en, cmp_en, logic_en, arith_en};

  // Unit model: flag rises lat[i] edges after the enable went high (lat=0 never answers).
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) cnt[i] <= en_v[i] ? cnt[i] + 1 : 0;
  end

  always_comb begin
    flag_v = '0;
    for (int i = 0; i < 4; i++)
      flag_v[i] = (en_v[i] && lat[i] != 0 && cnt[i] >= lat[i]) || force_v[i];
  end

  always_comb begin
    arith_out = {8'h00, unit_a} + {8'h00, unit_b};
    logic_out = {8'h00, unit_a & unit_b};
    cmp_out   = {15'h4000, unit_a < unit_b};
    case (unit_fuc)
      2'b00:   shift_out = {8'h00, unit_a};
      2'b01:   shift_out = {8'h00, unit_a} << 1;
      2'b10:   shift_out = {8'h00, unit_b} >> 1;
      default: shift_out = {8'h00, unit_a} << 4;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called on a negedge in IDLE; returns on the negedge after the accepting edge.
  task automatic issue(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    cmd_func  = f;
    cmd_a     = a;
    cmd_b     = b;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  func;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] data;
    logic [3:0]  en;
  } vec_t;

  vec_t vecs [4];
  int   n_en;

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_func  = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    res_ready = 1'b0;
    force_v   = '0;
    for (int i = 0; i < 4; i++) lat[i] = 1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_en", {28'h0, en_v}, 32'h0);
    check_eq("rst_valid", {31'h0, res_valid}, 32'h0);
    check_eq("rst_err", {31'h0, res_err}, 32'h0);
    check_eq("rst_clken", {31'h0, alu_clk_en}, 32'h0);
    check_eq("rst_data", {16'h0, res_data}, 32'h0);
    check_eq("rst_ops", {14'h0, unit_fuc, unit_a, unit_b}, 32'h0);
    rst = 1'b1;
    check_eq("rel_ready", {31'h0, cmd_ready}, 32'h1);

    // Shift left by one: 0x81 -> 0x0102, nominal latency
    issue(4'b1101, 8'h81, 8'h00);
    check_eq("t1_en_T0", {28'h0, en_v}, 32'h8);
    check_eq("t1_fuc", {30'h0, unit_fuc}, 32'h1);
    check_eq("t1_clken_exec", {31'h0, alu_clk_en}, 32'h1);
    check_eq("t1_ready_exec", {31'h0, cmd_ready}, 32'h0);
    @(negedge clk);
    check_eq("t1_valid_T1", {31'h0, res_valid}, 32'h0);
    @(negedge clk);
    check_eq("t1_valid_T2", {31'h0, res_valid}, 32'h1);
    check_eq("t1_data", {16'h0, res_data}, 32'h0102);
    check_eq("t1_err", {31'h0, res_err}, 32'h0);
    check_eq("t1_en_done", {28'h0, en_v}, 32'h0);
    check_eq("t1_clken_done1", {31'h0, alu_clk_en}, 32'h1);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check_eq("t1_idle_ready", {31'h0, cmd_ready}, 32'h1);
    check_eq("t1_idle_valid", {31'h0, res_valid}, 32'h0);
    check_eq("t1_idle_clken", {31'h0, alu_clk_en}, 32'h0);

    // Shift right of B: 0x10 -> 0x0008, held under back-pressure
    issue(4'b1110, 8'h00, 8'h10);
    @(negedge clk);
    @(negedge clk);
    cmd_func  = 4'b0000;
    cmd_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check_eq("t2_hold_valid", {31'h0, res_valid}, 32'h1);
      check_eq("t2_hold_data", {16'h0, res_data}, 32'h0008);
      check_eq("t2_hold_ready", {31'h0, cmd_ready}, 32'h0);
      if (k > 0) check_eq("t2_hold_clken", {31'h0, alu_clk_en}, 32'h0);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    check_eq("t2_back_idle", {31'h0, cmd_ready}, 32'h1);
    check_eq("t2_no_accept", {28'h0, en_v}, 32'h0);

    // Timeout: arith never answers
    lat[0] = 0;
    issue(4'b0000, 8'h05, 8'h06);
    n_en = 0;
    for (int k = 0; k < 20 && !res_valid; k++) begin
      if (arith_en) n_en++;
      @(negedge clk);
    end
    check_eq("t3_reached", {31'h0, res_valid}, 32'h1);
    check_eq("t3_en_cycles", n_en, 32'd4);
    check_eq("t3_err", {31'h0, res_err}, 32'h1);
    check_eq("t3_data", {16'h0, res_data}, 32'h0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;

    // Flag arrives on the timeout edge: result wins
    lat[0] = 3;
    issue(4'b0000, 8'h21, 8'h13);
    n_en = 0;
    for (int k = 0; k < 20 && !res_valid; k++) begin
      if (arith_en) n_en++;
      @(negedge clk);
    end
    check_eq("t3b_reached", {31'h0, res_valid}, 32'h1);
    check_eq("t3b_en_cycles", n_en, 32'd4);
    check_eq("t3b_err", {31'h0, res_err}, 32'h0);
    check_eq("t3b_data", {16'h0, res_data}, 32'h0034);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    lat[0] = 1;

    // Reset mid-EXEC
    lat[3] = 0;
    issue(4'b1101, 8'h55, 8'h00);
    check_eq("t4_en_before", {28'h0, en_v}, 32'h8);
    #2 rst = 1'b0;
    #1;
    check_eq("t4_en_async", {28'h0, en_v}, 32'h0);
    check_eq("t4_clken_async", {31'h0, alu_clk_en}, 32'h0);
    check_eq("t4_unit_a", {24'h0, unit_a}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    check_eq("t4_ready_rel", {31'h0, cmd_ready}, 32'h1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("t4_no_result", {31'h0, res_valid}, 32'h0);
    end
    lat[3] = 1;

    // Back-to-back, one per unit, res_ready held high
    vecs[0] = '{func: 4'b0001, a: 8'h12, b: 8'h34, data: 16'h0046, en: 4'b0001};
    vecs[1] = '{func: 4'b0110, a: 8'hF0, b: 8'h3C, data: 16'h0030, en: 4'b0010};
    vecs[2] = '{func: 4'b1000, a: 8'h05, b: 8'h09, data: 16'h8001, en: 4'b0100};
    vecs[3] = '{func: 4'b1111, a: 8'h0A, b: 8'h00, data: 16'h00A0, en: 4'b1000};
    res_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      issue(vecs[v].func, vecs[v].a, vecs[v].b);
      check_eq("t5_en_T0", {28'h0, en_v}, {28'h0, vecs[v].en});
      @(negedge clk);
      check_eq("t5_en_T1", {28'h0, en_v}, {28'h0, vecs[v].en});
      @(negedge clk);
      check_eq("t5_valid", {31'h0, res_valid}, 32'h1);
      check_eq("t5_data", {16'h0, res_data}, {16'h0, vecs[v].data});
      check_eq("t5_en_done", {28'h0, en_v}, 32'h0);
      @(negedge clk);
      check_eq("t5_idle", {31'h0, cmd_ready}, 32'h1);
    end
    res_ready = 1'b0;

    // Stray logic_flag during a slow cmp op
    lat[2]     = 2;
    force_v[1] = 1'b1;
    issue(4'b1000, 8'h0F, 8'hF3);
    @(negedge clk);
    @(negedge clk);
    check_eq("t6_not_yet", {31'h0, res_valid}, 32'h0);
    @(negedge clk);
    check_eq("t6_valid", {31'h0, res_valid}, 32'h1);
    check_eq("t6_data", {16'h0, res_data}, 32'h8001);
    check_eq("t6_err", {31'h0, res_err}, 32'h0);
    force_v[1] = 1'b0;
    res_ready  = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check_eq("t6_idle", {31'h0, cmd_ready}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 The block SHALL have parameter IN_WIDTH, default 8, meaning the operand width.
REQ-002 The block SHALL have parameter OUT_WIDTH, default 16, meaning the result width.
REQ-003 The block SHALL have parameter TIMEOUT, default 4, meaning the maximum EXEC cycles before abort; legal values are 2..15.
REQ-004 The block SHALL have port clk, input, 1, meaning the clock.
REQ-005 The block SHALL have port rst, input, 1, meaning the reset, which is asynchronous and active-low.
REQ-006 The block SHALL have ports cmd_valid input 1, cmd_ready output 1, cmd_func input 4, cmd_a input IN_WIDTH and cmd_b input IN_WIDTH, forming the command handshake.
REQ-007 The block SHALL have outputs unit_a and unit_b, each IN_WIDTH, meaning the registered operands driven to the units.
REQ-008 The block SHALL have output unit_fuc, 2 bits, meaning the registered function code (cmd_func[1:0]).
REQ-009 The block SHALL have outputs arith_en, logic_en, cmp_en and shift_en, 1 bit each, meaning the per-unit enables.
REQ-010 The block SHALL have inputs arith_flag, logic_flag, cmp_flag and shift_flag, 1 bit each, meaning the per-unit result-valid flags.
REQ-011 The block SHALL have inputs arith_out, logic_out, cmp_out and shift_out, each OUT_WIDTH, meaning the per-unit results.
REQ-012 The block SHALL have outputs res_valid 1, res_data OUT_WIDTH and res_err 1, and input res_ready 1, forming the result handshake.
REQ-013 The block SHALL have output alu_clk_en, 1 bit, meaning the clock-gate enable for the ALU domain.

Function
REQ-014 The block SHALL implement the states IDLE, EXEC and DONE.
REQ-015 cmd_ready SHALL be 1 only in IDLE, and a command SHALL be accepted on any edge where cmd_valid=1 and cmd_ready=1.
REQ-016 On acceptance, the block SHALL register cmd_a to unit_a, cmd_b to unit_b, cmd_func[1:0] to unit_fuc and cmd_func[3:2] to sel, then enter EXEC.
REQ-017 sel SHALL decode as 00=arith, 01=logic, 10=cmp and 11=shift.
REQ-018 In EXEC, exactly the one enable selected by sel SHALL be 1; all enables SHALL be 0 in IDLE and DONE.
REQ-019 In EXEC, on an edge where the selected flag=1, the block SHALL capture the selected result into res_data, set res_err=0 and enter DONE.
REQ-020 Flags and results of non-selected units SHALL be ignored.
REQ-021 The timeout counter SHALL clear on entry to EXEC and increment on each EXEC cycle.
REQ-022 If the counter reaches TIMEOUT-1 with the selected flag still 0, the block SHALL set res_data=0 and res_err=1, then enter DONE.
REQ-023 If the flag and the timeout occur on the same edge, the flag SHALL win: capture the result with res_err=0.
REQ-024 Nominal latency: a command accepted at edge T0 SHALL drive its enable during T0..T1, the unit flag SHALL be seen at edge T2, and res_valid SHALL be 1 after T2.
REQ-025 res_valid SHALL be 1 only in DONE, and res_data and res_err SHALL be held stable while res_valid=1 and res_ready=0.
REQ-026 In DONE, when res_ready=1, the block SHALL return to IDLE on that edge, and no new command SHALL be accepted on that edge.
REQ-027 alu_clk_en SHALL be 1 in EXEC and for the first cycle of DONE, and 0 otherwise.
REQ-028 cmd_func values SHALL carry no illegal encodings; all 16 values SHALL be valid.

Reset
REQ-029 On rst=0 (asynchronous), the block SHALL enter IDLE.
REQ-030 During and after reset, all enables, res_valid, res_err and alu_clk_en SHALL be 0, and res_data, unit_a, unit_b, unit_fuc, sel and the counter SHALL be 0.
REQ-031 Reset asserted mid-EXEC SHALL drop the enable immediately (asynchronously), discard the operation, and produce no result after release.
REQ-032 After release, cmd_ready SHALL be 1 in the first cycle.

Structure
REQ-033 Package alu_seq_pkg SHALL hold the state encoding (IDLE/EXEC/DONE) and the unit-select constants (SEL_ARITH, SEL_LOGIC, SEL_CMP, SEL_SHIFT).
REQ-034 One sub-module, seq_timeout_cnt, SHALL be used, with a 4-bit clear/increment counter and an expired output compared against TIMEOUT-1.
REQ-035 The result mux SHALL be combinational on sel, and all outputs SHALL be registered except cmd_ready, res_valid and the enables, which are decoded from the state register.

Verification
REQ-036 cmd_func=4'b1101, A=8'h81, shift model -> shift_en=1, unit_fuc=01, res_data=16'h0102, res_err=0, res_valid at T2.
REQ-037 cmd_func=4'b1110, B=8'h10, res_ready held 0 for 5 cycles -> res_data=16'h0008 stable, cmd_ready=0 throughout, IDLE one edge after res_ready=1.
REQ-038 cmd_func=4'b0000, arith_flag tied 0, TIMEOUT=4 -> arith_en high 4 cycles, res_err=1, res_data=0.
REQ-039 rst pulsed low during EXEC of a shift op -> shift_en=0 immediately, no res_valid after release, cmd_ready=1 next cycle.
REQ-040 Four back-to-back commands (one per unit) with res_ready=1 -> each completes in 3 cycles plus 1 return cycle, the correct enable for each, with no enable overlap.
REQ-041 Non-selected logic_flag=1 during a cmp op with cmp_flag delayed 2 cycles -> result taken from cmp_out only.
